// File: rtl/mat_fifo_frame_reader.sv
// mat_fifo_frame_reader
//   Read-side controller for the mat_fifo show-ahead FIFO. Pops pixel words
//   with the FIFO rd_en/rd_vld handshake, tags each with its frame position
//   (SOF/EOL/EOF) and presents it on a valid/ready stream. A 2-entry skid
//   buffer keeps fifo_rd_en free of any combinational dependence on m_ready.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   start               1-cycle pulse, arms one frame (IDLE only)
//   abort               drop current frame, back to IDLE next cycle
//   fifo_rd_en          pop FIFO head word (out)
//   fifo_rd_vld         FIFO head word valid (in)
//   fifo_rd_data        FIFO head word (in)
//   m_valid/m_ready     output stream handshake
//   m_data              pixel
//   m_sof/m_eol/m_eof   first pixel of frame / last of line / last of frame
//   busy                controller not idle
//   frame_done          1-cycle pulse after the EOF pixel is accepted
//   timeout_err         1-cycle pulse on starvation abort
//
// Configuration
//   MAT_FIFO_RD_TIMEOUT_EN  defined: abort after TIMEOUT_CYC cycles in RUN
//                           with no FIFO data. Undefined: RUN waits forever
//                           and timeout_err is tied 0.

module mat_fifo_frame_reader #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned IMG_WIDTH   = 640,
  parameter int unsigned IMG_HEIGHT  = 480,
  parameter int unsigned CNT_WIDTH   = 12,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  fifo_rd_en,
  input  logic                  fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  timeout_err
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sof;
    logic                  eol;
    logic                  eof;
  } word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(IMG_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(IMG_HEIGHT - 1);

  state_t               state;
  state_t               state_nxt;
  word_t                skid0;
  word_t                skid1;
  word_t                pop_word;
  logic [1:0]           skid_cnt;
  logic [CNT_WIDTH-1:0] col;
  logic [CNT_WIDTH-1:0] row;
  logic                 pop;
  logic                 xfer;
  logic                 timeout_hit;
  logic                 abort_any;

  assign pop       = fifo_rd_en;
  assign xfer      = m_valid & m_ready;
  assign abort_any = abort | timeout_hit;

  // Output stream comes straight from the skid head register.
  assign m_valid = (skid_cnt != 2'd0);
  assign m_data  = skid0.data;
  assign m_sof   = skid0.sof;
  assign m_eol   = skid0.eol;
  assign m_eof   = skid0.eof;

  // Tags for the word being popped, from the position counters.
  always_comb begin
    pop_word      = '0;
    pop_word.data = fifo_rd_data;
    pop_word.sof  = (col == '0) && (row == '0);
    pop_word.eol  = (col == COL_LAST);
    pop_word.eof  = (col == COL_LAST) && (row == ROW_LAST);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort (or starvation) overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (pop && pop_word.eof) state_nxt = DRAIN;
      // Leave as soon as the last skid entry is being transferred.
      DRAIN:   if ((skid_cnt == 2'd0) || ((skid_cnt == 2'd1) && xfer)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_any) state_nxt = IDLE;
  end

  // State-decoded outputs; popping only needs registered skid occupancy.
  always_comb begin
    busy       = 1'b0;
    frame_done = 1'b0;
    fifo_rd_en = 1'b0;
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    fifo_rd_en = (state == RUN) && fifo_rd_vld && (skid_cnt != 2'd2);
  end

  // Skid buffer: skid0 is the head, skid1 only used when two words are held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_cnt <= 2'd0;
      skid0    <= '0;
      skid1    <= '0;
    end else if (abort_any) begin
      skid_cnt <= 2'd0;
      skid0    <= '0;
      skid1    <= '0;
    end else begin
      case (skid_cnt)
        2'd0: begin
          if (pop) begin
            skid0    <= pop_word;
            skid_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && xfer) begin
            skid0 <= pop_word;
          end else if (pop) begin
            skid1    <= pop_word;
            skid_cnt <= 2'd2;
          end else if (xfer) begin
            skid_cnt <= 2'd0;
          end
        end
        2'd2: begin
          if (xfer) begin
            skid0    <= skid1;
            skid_cnt <= 2'd1;
          end
        end
        default: skid_cnt <= 2'd0;
      endcase
    end
  end

  // Frame position counters, advanced per popped word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (abort_any || (state == IDLE)) begin
      col <= '0;
      row <= '0;
    end else if (pop) begin
      if (pop_word.eol) begin
        col <= '0;
        row <= pop_word.eof ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

`ifdef MAT_FIFO_RD_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] starve_cnt;

  // Cycles spent in RUN with an empty FIFO since the last pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if ((state != RUN) || pop || abort) begin
      starve_cnt <= '0;
    end else if (!fifo_rd_vld && !timeout_hit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == RUN) && (starve_cnt == TO_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_err <= 1'b0;
    else     timeout_err <= timeout_hit;
  end
`else
  logic unused_timeout_cyc;

  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
  assign timeout_hit        = 1'b0;
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mat_fifo_frame_reader.sv
// Bench for mat_fifo_frame_reader with a 4x2 frame and a behavioural
// show-ahead FIFO.
module tb_mat_fifo_frame_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 4;
  localparam int unsigned IH = 2;
  localparam int unsigned CW = 12;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          fifo_rd_en;
  logic          fifo_rd_vld;
  logic [DW-1:0] fifo_rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_sof;
  logic          m_eol;
  logic          m_eof;
  logic          busy;
  logic          frame_done;
  logic          timeout_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mat_fifo_frame_reader #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH),
    .CNT_WIDTH  (CW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_vld (fifo_rd_vld),
    .fifo_rd_data(fifo_rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_sof       (m_sof),
    .m_eol       (m_eol),
    .m_eof       (m_eof),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
  );

  // Behavioural show-ahead FIFO.
  logic [DW-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic pop_pend = 1'b0;

  assign fifo_rd_vld  = (wr_ptr != rd_ptr);
  assign fifo_rd_data = mem[rd_ptr[5:0]];

  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pop_pend) rd_ptr <= rd_ptr + 1;
  end

  // Monitor: records accepted words and protocol violations.
  logic [10:0] got [0:255];
  int  got_cyc [0:255];
  int  got_n = 0;
  int  fd_cnt = 0;
  int  fd_cyc = 0;
  int  to_cnt = 0;
  int  occ = 0;
  int  occ_viol = 0;
  int  uf_viol = 0;
  int  stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic        prev_abort = 1'b0;
  logic [10:0] prev_word = '0;

  always @(negedge clk) begin
    pop_pend <= fifo_rd_en && !rst;
    if (rst) begin
      occ        = 0;
      prev_stall = 1'b0;
    end else begin
      if (fifo_rd_en && !fifo_rd_vld) uf_viol++;
      if (fifo_rd_en && occ == 2) occ_viol++;
      if (prev_stall && !prev_abort &&
          (!m_valid || {m_data, m_sof, m_eol, m_eof} != prev_word)) stall_viol++;
      if (m_valid && m_ready) begin
        got[got_n[7:0]]     = {m_data, m_sof, m_eol, m_eof};
        got_cyc[got_n[7:0]] = cyc;
        got_n++;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (timeout_err) to_cnt++;
      occ = occ + (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      if (abort || timeout_err) occ = 0;
      prev_stall = m_valid && !m_ready;
      prev_abort = abort;
      prev_word  = {m_data, m_sof, m_eol, m_eof};
    end
  end

  // Expected {data, sof, eol, eof} for pixel index idx of a 4x2 frame.
  function automatic logic [10:0] exp_word(input int idx, input int d);
    exp_word = {8'(d), (idx == 0), ((idx % IW) == IW - 1), (idx == IW * IH - 1)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d);
    mem[wr_ptr[5:0]] = 8'(d);
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic preload(input int first, input int n);
    for (int i = 0; i < n; i++) push(first + i);
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_n >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_fd(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (fd_cnt >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    step(); step();
    checks++; if (m_valid !== 1'b0) begin $display("FAIL reset_m_valid got=%b exp=0", m_valid); errors++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", busy); errors++; end
    checks++; if (fifo_rd_en !== 1'b0) begin $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); errors++; end
    checks++; if ({m_data, m_sof, m_eol, m_eof} !== 11'h0) begin
      $display("FAIL reset_m_word got=%h exp=000", {m_data, m_sof, m_eol, m_eof}); errors++; end
    checks++; if ({frame_done, timeout_err} !== 2'b00) begin
      $display("FAIL reset_pulses got=%b exp=00", {frame_done, timeout_err}); errors++; end
    rst = 1'b0;
    step();
    checks++; if ({busy, m_valid} !== 2'b00) begin
      $display("FAIL post_reset_idle got=%b exp=00", {busy, m_valid}); errors++; end
  endtask

  task automatic test_basic_frame();
    int base, fdb;
    bit ok;
    base = got_n; fdb = fd_cnt;
    m_ready = 1'b1;
    preload(0, 8);
    pulse_start();
    wait_fd(fdb + 1, 60, ok);
    checks++; if (!ok) begin $display("FAIL t1_frame_done_timeout got=0 exp=1"); errors++; end
    checks++; if (got_n - base !== 8) begin $display("FAIL t1_count got=%0d exp=8", got_n - base); errors++; end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[8'(base + i)] !== exp_word(i, i)) begin
        $display("FAIL t1_word%0d got=%h exp=%h", i, got[8'(base + i)], exp_word(i, i)); errors++;
      end
    end
    checks++; if (got_cyc[8'(base + 7)] - got_cyc[8'(base)] !== 7) begin
      $display("FAIL t1_throughput got=%0d exp=7", got_cyc[8'(base + 7)] - got_cyc[8'(base)]); errors++; end
    checks++; if (fd_cyc !== got_cyc[8'(base + 7)] + 1) begin
      $display("FAIL t1_done_latency got=%0d exp=%0d", fd_cyc, got_cyc[8'(base + 7)] + 1); errors++; end
    checks++; if ({busy, frame_done} !== 2'b00) begin
      $display("FAIL t1_idle_after got=%b exp=00", {busy, frame_done}); errors++; end
    step(); step();
    checks++; if (fd_cnt - fdb !== 1) begin $display("FAIL t1_done_pulses got=%0d exp=1", fd_cnt - fdb); errors++; end
  endtask

  task automatic test_backpressure();
    int base, fdb, ov, sv;
    base = got_n; fdb = fd_cnt; ov = occ_viol; sv = stall_viol;
    m_ready = 1'b0;
    preload(0, 8);
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      if (fd_cnt > fdb) break;
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    m_ready = 1'b1;
    checks++; if (fd_cnt - fdb !== 1) begin $display("FAIL t2_frame_done got=%0d exp=1", fd_cnt - fdb); errors++; end
    checks++; if (got_n - base !== 8) begin $display("FAIL t2_count got=%0d exp=8", got_n - base); errors++; end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[8'(base + i)] !== exp_word(i, i)) begin
        $display("FAIL t2_word%0d got=%h exp=%h", i, got[8'(base + i)], exp_word(i, i)); errors++;
      end
    end
    checks++; if (stall_viol - sv !== 0) begin $display("FAIL t2_stall_stable got=%0d exp=0", stall_viol - sv); errors++; end
    checks++; if (occ_viol - ov !== 0) begin $display("FAIL t2_pop_when_full got=%0d exp=0", occ_viol - ov); errors++; end
  endtask

  task automatic test_fifo_gap();
    int base, fdb, tob, en_seen;
    bit ok;
    base = got_n; fdb = fd_cnt; tob = to_cnt; en_seen = 0;
    m_ready = 1'b1;
    preload(0, 3);
    pulse_start();
    wait_words(base + 3, 30, ok);
    checks++; if (!ok) begin $display("FAIL t3_first3_timeout got=0 exp=1"); errors++; end
    for (int i = 0; i < 10; i++) begin
      if (fifo_rd_en !== 1'b0) en_seen++;
      step();
    end
    checks++; if (en_seen !== 0) begin $display("FAIL t3_rd_en_in_gap got=%0d exp=0", en_seen); errors++; end
    checks++; if (busy !== 1'b1) begin $display("FAIL t3_busy_in_gap got=%b exp=1", busy); errors++; end
    checks++; if (to_cnt - tob !== 0) begin $display("FAIL t3_no_timeout got=%0d exp=0", to_cnt - tob); errors++; end
    preload(3, 5);
    wait_fd(fdb + 1, 60, ok);
    checks++; if (!ok) begin $display("FAIL t3_frame_done_timeout got=0 exp=1"); errors++; end
    checks++; if (got_n - base !== 8) begin $display("FAIL t3_count got=%0d exp=8", got_n - base); errors++; end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[8'(base + i)] !== exp_word(i, i)) begin
        $display("FAIL t3_word%0d got=%h exp=%h", i, got[8'(base + i)], exp_word(i, i)); errors++;
      end
    end
  endtask

  task automatic test_abort();
    int base, fdb;
    bit ok;
    base = got_n; fdb = fd_cnt;
    m_ready = 1'b1;
    preload(0, 8);
    pulse_start();
    wait_words(base + 3, 30, ok);
    checks++; if (!ok) begin $display("FAIL t4_first3_timeout got=0 exp=1"); errors++; end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if ({busy, m_valid, fifo_rd_en} !== 3'b000) begin
      $display("FAIL t4_idle_after_abort got=%b exp=000", {busy, m_valid, fifo_rd_en}); errors++; end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[8'(base + i)] !== exp_word(i, i)) begin
        $display("FAIL t4_prefix%0d got=%h exp=%h", i, got[8'(base + i)], exp_word(i, i)); errors++;
      end
    end
    step(); step(); step();
    checks++; if (fd_cnt - fdb !== 0) begin $display("FAIL t4_no_frame_done got=%0d exp=0", fd_cnt - fdb); errors++; end
    flush();
    base = got_n;
    preload(8'h20, 8);
    pulse_start();
    wait_fd(fdb + 1, 60, ok);
    checks++; if (!ok) begin $display("FAIL t4_restart_timeout got=0 exp=1"); errors++; end
    checks++; if (got[8'(base)] !== exp_word(0, 8'h20)) begin
      $display("FAIL t4_restart_sof got=%h exp=%h", got[8'(base)], exp_word(0, 8'h20)); errors++; end
    checks++; if (got[8'(base + 7)] !== exp_word(7, 8'h27)) begin
      $display("FAIL t4_restart_eof got=%h exp=%h", got[8'(base + 7)], exp_word(7, 8'h27)); errors++; end
  endtask

  task automatic test_timeout();
    int base, fdb, tob;
    bit ok;
    base = got_n; fdb = fd_cnt; tob = to_cnt;
    m_ready = 1'b1;
    preload(0, 4);
    pulse_start();
    wait_words(base + 4, 30, ok);
    checks++; if (!ok) begin $display("FAIL t5_first4_timeout got=0 exp=1"); errors++; end
`ifdef MAT_FIFO_RD_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      if (to_cnt > tob) break;
      step();
    end
    checks++; if (to_cnt - tob !== 1) begin $display("FAIL t5_timeout_pulse got=%0d exp=1", to_cnt - tob); errors++; end
    checks++; if ({busy, timeout_err, m_valid} !== 3'b000) begin
      $display("FAIL t5_idle_after_timeout got=%b exp=000", {busy, timeout_err, m_valid}); errors++; end
    checks++; if (fd_cnt - fdb !== 0) begin $display("FAIL t5_no_frame_done got=%0d exp=0", fd_cnt - fdb); errors++; end
`else
    for (int i = 0; i < 30; i++) step();
    checks++; if (busy !== 1'b1) begin $display("FAIL t5_busy_waits got=%b exp=1", busy); errors++; end
    checks++; if (to_cnt - tob !== 0 || timeout_err !== 1'b0) begin
      $display("FAIL t5_no_timeout got=%0d exp=0", to_cnt - tob); errors++; end
    preload(4, 4);
    wait_fd(fdb + 1, 60, ok);
    checks++; if (!ok) begin $display("FAIL t5_resume_timeout got=0 exp=1"); errors++; end
    checks++; if (got[8'(base + 4)] !== exp_word(4, 4)) begin
      $display("FAIL t5_resume_word got=%h exp=%h", got[8'(base + 4)], exp_word(4, 4)); errors++; end
`endif
    flush();
  endtask

  task automatic test_reset_and_restart();
    int base, fdb;
    bit ok;
    base = got_n;
    m_ready = 1'b1;
    preload(0, 8);
    pulse_start();
    wait_words(base + 3, 30, ok);
    checks++; if (!ok) begin $display("FAIL t6_first3_timeout got=0 exp=1"); errors++; end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, m_valid, fifo_rd_en, frame_done, timeout_err} !== 5'b0) begin
      $display("FAIL t6_async_reset_ctl got=%b exp=00000",
               {busy, m_valid, fifo_rd_en, frame_done, timeout_err}); errors++; end
    checks++; if ({m_data, m_sof, m_eol, m_eof} !== 11'h0) begin
      $display("FAIL t6_async_reset_word got=%h exp=000", {m_data, m_sof, m_eol, m_eof}); errors++; end
    step();
    rst = 1'b0;
    step();
    flush();
    base = got_n; fdb = fd_cnt;
    preload(0, 12);
    pulse_start();
    step(); step();
    pulse_start();
    wait_fd(fdb + 1, 60, ok);
    checks++; if (!ok) begin $display("FAIL t6_frame_done_timeout got=0 exp=1"); errors++; end
    for (int i = 0; i < 10; i++) step();
    checks++; if (got_n - base !== 8) begin $display("FAIL t6_frame_len got=%0d exp=8", got_n - base); errors++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL t6_idle_after got=%b exp=0", busy); errors++; end
    checks++; if (wr_ptr - rd_ptr !== 4) begin $display("FAIL t6_fifo_left got=%0d exp=4", wr_ptr - rd_ptr); errors++; end
    checks++; if (got[8'(base + 7)] !== exp_word(7, 7)) begin
      $display("FAIL t6_eof_word got=%h exp=%h", got[8'(base + 7)], exp_word(7, 7)); errors++; end
    checks++; if (uf_viol !== 0) begin $display("FAIL underflow_pops got=%0d exp=0", uf_viol); errors++; end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_fifo_gap();
    test_abort();
    test_timeout();
    test_reset_and_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
